// File: rtl/letc_core_pkg.sv
// rtl/letc_core_pkg.sv - CSR indices, write-op encoding and field masks for the LETC core
package letc_core_pkg;

  typedef enum logic [1:0] {
    CSR_WOP_NONE = 2'b00,
    CSR_WOP_W    = 2'b01,
    CSR_WOP_S    = 2'b10,
    CSR_WOP_C    = 2'b11
  } csr_wop_e;

  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] csr_apply_wop(input logic [31:0] old,
                                                input logic [31:0] operand,
                                                input csr_wop_e    op);
    case (op)
      CSR_WOP_W: csr_apply_wop = operand;
      CSR_WOP_S: csr_apply_wop = old | operand;
      CSR_WOP_C: csr_apply_wop = old & ~operand;
      default:   csr_apply_wop = old;
    endcase
  endfunction

endpackage

// File: rtl/letc_core_csr_counter64.sv
// rtl/letc_core_csr_counter64.sv - 64-bit event counter with inhibit and independent lo/hi half writes
module letc_core_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        wen_lo_i,
  input  logic        wen_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    // Any half write suppresses this cycle's increment so the written value reads back unchanged.
    if (wen_lo_i || wen_hi_i) begin
      if (wen_lo_i) count_d[31:0]  = wdata_i;
      if (wen_hi_i) count_d[63:32] = wdata_i;
    end else if (inc_i && !inhibit_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/letc_core_csr_bank.sv
// rtl/letc_core_csr_bank.sv - machine-mode CSR bank: RMW writes, 64-bit counters, trap capture
// HPM counters, shadows and inhibit bits exist only when LETC_CSR_HPM_EN is defined.
module letc_core_csr_bank
  import letc_core_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter int unsigned NUM_HPM     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_explicit_ren,
  input  logic [11:0]        csr_explicit_idx,
  output logic [31:0]        csr_explicit_rdata,
  input  logic               csr_explicit_wcheck,
  output logic               csr_explicit_illegal,
  input  logic               csr_explicit_wen,
  input  logic [11:0]        csr_explicit_widx,
  input  logic [1:0]         csr_explicit_wop,
  input  logic [31:0]        csr_explicit_wdata,
  input  logic               instret_inc,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic               trap_valid,
  input  logic [31:0]        trap_pc,
  input  logic [31:0]        trap_cause,
  output logic [31:0]        mtvec,
  output logic [31:0]        mepc
);

`ifdef LETC_CSR_HPM_EN
  localparam bit HPM_EN = 1'b1;
`else
  localparam bit HPM_EN = 1'b0;
`endif
  // Counter slot n maps to index 0xB00+n and to mcountinhibit bit n.
  localparam logic [31:0] CNT_IMPL  = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
  localparam logic [31:0] INH_WMASK = HPM_EN ? CNT_IMPL : 32'h5;

  logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] mtvec_q, mtvec_d, minh_q, minh_d;
  logic [63:0] mcycle_val, minstret_val;
  logic [63:0] hpm_val [NUM_HPM];
  logic [63:0] cnt_val [32];
  logic [31:0] cnt_wen_lo, cnt_wen_hi;
  logic [32:0] rd_res, wr_old;
  logic [31:0] wr_val;
  logic        wr_ok;

  always_comb begin
    for (int i = 0; i < 32; i++) cnt_val[i] = '0;
    cnt_val[0] = mcycle_val;
    cnt_val[2] = minstret_val;
    for (int i = 0; i < NUM_HPM; i++) cnt_val[3+i] = hpm_val[i];
  end

  // Returns {implemented, value}; unimplemented indices read 0.
  function automatic logic [32:0] csr_read(input logic [11:0] idx);
    logic [4:0] n;
    n = idx[4:0];
    csr_read = '0;
    case (idx)
      CSR_MSCRATCH:      csr_read = {1'b1, mscratch_q};
      CSR_MEPC:          csr_read = {1'b1, mepc_q};
      CSR_MCAUSE:        csr_read = {1'b1, mcause_q};
      CSR_MTVEC:         csr_read = {1'b1, mtvec_q};
      CSR_MCOUNTINHIBIT: csr_read = {1'b1, minh_q};
      CSR_MHARTID:       csr_read = {1'b1, HART_ID};
      default: begin
        if ((idx[11:5] == CSR_MCYCLE[11:5] || idx[11:5] == CSR_MCYCLEH[11:5] ||
             idx[11:5] == CSR_CYCLE[11:5]  || idx[11:5] == CSR_CYCLEH[11:5]) && CNT_IMPL[n])
          csr_read = {1'b1, idx[7] ? cnt_val[n][63:32] : cnt_val[n][31:0]};
      end
    endcase
  endfunction

  always_comb begin
    rd_res = csr_read(csr_explicit_idx);
    wr_old = csr_read(csr_explicit_widx);
    wr_ok  = csr_explicit_wen && (csr_explicit_wop != CSR_WOP_NONE) && wr_old[32] &&
             (csr_explicit_widx[11:10] != 2'b11);
    wr_val = csr_apply_wop(wr_old[31:0], csr_explicit_wdata, csr_wop_e'(csr_explicit_wop));
  end

  assign csr_explicit_rdata   = rd_res[31:0];
  assign csr_explicit_illegal = ((csr_explicit_ren || csr_explicit_wcheck) && !rd_res[32]) ||
                                (csr_explicit_wcheck && csr_explicit_idx[11:10] == 2'b11);

  always_comb begin
    cnt_wen_lo = '0;
    cnt_wen_hi = '0;
    if (wr_ok && csr_explicit_widx[11:5] == CSR_MCYCLE[11:5])  cnt_wen_lo[csr_explicit_widx[4:0]] = 1'b1;
    if (wr_ok && csr_explicit_widx[11:5] == CSR_MCYCLEH[11:5]) cnt_wen_hi[csr_explicit_widx[4:0]] = 1'b1;
  end

  always_comb begin
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtvec_d    = mtvec_q;
    minh_d     = minh_q;
    if (wr_ok) begin
      case (csr_explicit_widx)
        CSR_MSCRATCH:      mscratch_d = wr_val;
        CSR_MEPC:          mepc_d     = wr_val & MEPC_WMASK;
        CSR_MCAUSE:        mcause_d   = wr_val;
        CSR_MTVEC:         mtvec_d    = wr_val & MTVEC_WMASK;
        CSR_MCOUNTINHIBIT: minh_d     = wr_val & INH_WMASK;
        default: ;
      endcase
    end
    // Trap capture wins over an explicit write to the same register.
    if (trap_valid) begin
      mepc_d   = trap_pc & MEPC_WMASK;
      mcause_d = trap_cause;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtvec_q    <= MTVEC_RESET;
      minh_q     <= '0;
    end else begin
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtvec_q    <= mtvec_d;
      minh_q     <= minh_d;
    end
  end

  letc_core_csr_counter64 u_mcycle (
    .clk(clk), .rst(rst), .inc_i(1'b1), .inhibit_i(minh_q[0]),
    .wen_lo_i(cnt_wen_lo[0]), .wen_hi_i(cnt_wen_hi[0]), .wdata_i(wr_val), .count_o(mcycle_val)
  );

  letc_core_csr_counter64 u_minstret (
    .clk(clk), .rst(rst), .inc_i(instret_inc), .inhibit_i(minh_q[2]),
    .wen_lo_i(cnt_wen_lo[2]), .wen_hi_i(cnt_wen_hi[2]), .wdata_i(wr_val), .count_o(minstret_val)
  );

`ifdef LETC_CSR_HPM_EN
  for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
    letc_core_csr_counter64 u_hpm (
      .clk(clk), .rst(rst), .inc_i(hpm_event[i]), .inhibit_i(minh_q[3+i]),
      .wen_lo_i(cnt_wen_lo[3+i]), .wen_hi_i(cnt_wen_hi[3+i]), .wdata_i(wr_val), .count_o(hpm_val[i])
    );
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_HPM; i++) hpm_val[i] = '0;
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{cnt_wen_lo, cnt_wen_hi, hpm_event};

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

endmodule
